pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Sequencer that drives the configuration bus of pwm_bus_interface (clk_freq, pwm_freq, duty, sync). On a start command it latches a new frequency pair and a target duty, then ramps duty toward the target in bounded steps. Each update is committed with a one-cycle sync pulse, and consecutive updates are separated by a programmable dwell. It sits between the host/register block and pwm_bus_interface, which must only ever see clean, synced changes.

Parameters:
INIT_DUTY, 32'h00000000, duty output value after reset
DEF_CLK_FREQ, 32'd1000000, clk_freq output after reset (kHz)
DEF_PWM_FREQ, 32'd10000, pwm_freq output after reset (kHz)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a ramp; sampled only in IDLE
abort  in  1  cancel a ramp; priority over start
target_duty  in  32  final duty, unsigned fraction of full scale
step  in  32  maximum duty change per update; 0 = jump directly to target
hold_cycles  in  32  dwell cycles between updates
cfg_clk_freq  in  32  new clk_freq (kHz), latched at start
cfg_pwm_freq  in  32  new pwm_freq (kHz), latched at start
clk_freq  out  32  to pwm_bus_interface
pwm_freq  out  32  to pwm_bus_interface
duty  out  32  to pwm_bus_interface
sync  out  1  commit pulse to pwm_bus_interface
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a ramp completes normally

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE; duty=INIT_DUTY; clk_freq=DEF_CLK_FREQ; pwm_freq=DEF_PWM_FREQ; sync=0; busy=0; done=0; internal latches and counter cleared. Reset during a ramp therefore discards the ramp and restores the defaults.
- All outputs are registered.
- States: IDLE, STEP, SYNC, WAIT, DONE.
- IDLE: on start=1 and abort=0, latch target_duty, step, hold_cycles and both cfg freqs, set first=1, and go to STEP. busy rises in the cycle after start. While not in IDLE, start is ignored and the inputs are not re-latched.
- STEP (1 cycle):
  - If duty==target and first=0: go to DONE.
  - Otherwise: go to SYNC and register the new duty.
  - New duty, step=0: duty=target.
  - New duty, duty<target: min(duty+step, target), computed in 33 bits, so there is no wrap past 32'hFFFFFFFF.
  - New duty, duty>target: max(duty-step, target), computed in 33 bits, so there is no underflow.
  - New duty, duty==target (first=1 only): duty unchanged.
  - On first=1, clk_freq and pwm_freq also load the latched values, then first clears. The first update always issues one sync, even when duty already equals target.
- SYNC (1 cycle): sync=1. The new duty and freqs are already stable on the outputs in this same cycle.
  - If hold_cycles==0: go to STEP.
  - Otherwise: load the counter with hold_cycles and go to WAIT.
- WAIT: decrement the counter each cycle. Leave for STEP in the cycle where the counter reads 1. WAIT lasts exactly hold_cycles cycles.
- Sync-to-sync spacing is hold_cycles+2 cycles.
- DONE (1 cycle): done=1, busy=1; next state is IDLE.
- abort=1 in STEP, SYNC or WAIT: next state is IDLE. duty and freqs hold their current values, no further sync, no done pulse. If abort=1 in SYNC, that cycle's sync still shows 1, because it is registered from the prior edge. abort in IDLE or DONE has no effect.
- sync and done are never high in the same cycle.

Test Plan:
1. After reset: duty=0, clk_freq=1000000, pwm_freq=10000, sync=0, busy=0. Pulse start with target=32'h7FFFFFFF, step=32'h20000000, hold=3 -> duty at successive syncs is 20000000, 40000000, 60000000, 7FFFFFFF; exactly 4 syncs 5 cycles apart; freqs update at the first sync; done pulses 5 cycles after the last sync; busy falls the next cycle.
2. Saturation: up-ramp with duty=F0000000, target=FFFFFFFF, step=20000000 -> a single sync with duty=FFFFFFFF and no wrap. Down-ramp with duty=7FFFFFFF, target=00000010, step=80000000 -> a single sync with duty=00000010.
3. step=0, hold=0, target=12345678 -> exactly one sync with duty=12345678, then done.
4. target equal to the current duty, new cfg_pwm_freq=20000 -> exactly one sync with duty unchanged and pwm_freq=20000, then done.
5. abort in WAIT after the 2nd sync of scenario 1 -> IDLE next cycle, duty stays 40000000, no done pulse, no further sync. A start held high during the ramp is ignored.
6. rst asserted mid-WAIT -> all outputs return to their parameter defaults at the next edge; a following start runs a normal ramp.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequences clean, synced configuration updates to pwm_bus_interface.
// On start it latches a frequency pair and a target duty, then steps duty toward the
// target by at most 'step' per update, committing each update with a one-cycle sync
// pulse and dwelling hold_cycles cycles between updates.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   start, abort              begin a ramp (IDLE only) / cancel a ramp (priority)
//   target_duty, step         final duty and maximum change per update (0 = jump)
//   hold_cycles               dwell cycles between updates
//   cfg_clk_freq/pwm_freq     frequency pair latched at start
//   clk_freq, pwm_freq, duty  registered configuration bus outputs
//   sync                      registered commit pulse
//   busy, done                not-idle flag, ramp-complete pulse
module pwm_ramp_ctrl #(
    parameter logic [31:0] INIT_DUTY    = 32'h0000_0000,
    parameter logic [31:0] DEF_CLK_FREQ = 32'd1000000,
    parameter logic [31:0] DEF_PWM_FREQ = 32'd10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] target_duty,
    input  logic [31:0] step,
    input  logic [31:0] hold_cycles,
    input  logic [31:0] cfg_clk_freq,
    input  logic [31:0] cfg_pwm_freq,
    output logic [31:0] clk_freq,
    output logic [31:0] pwm_freq,
    output logic [31:0] duty,
    output logic        sync,
    output logic        busy,
    output logic        done
);

    localparam int unsigned W = 32;

    typedef enum logic [2:0] {IDLE, STEP, SYNC, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   tgt_q, tgt_d;
    logic [W-1:0]   step_q, step_d;
    logic [W-1:0]   hold_q, hold_d;
    logic [W-1:0]   cfg_clk_q, cfg_clk_d;
    logic [W-1:0]   cfg_pwm_q, cfg_pwm_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           first_q, first_d;
    logic [W-1:0]   duty_d, clk_freq_d, pwm_freq_d;
    logic           sync_d, busy_d, done_d;
    logic [W-1:0]   step_duty;
    logic [W:0]     up_sum, dn_diff;

    // Next duty value for one update, saturating at the target in 33-bit arithmetic.
    always_comb begin
        up_sum    = {1'b0, duty} + {1'b0, step_q};
        dn_diff   = {1'b0, duty} - {1'b0, step_q};
        step_duty = duty;
        if (step_q == '0) begin
            step_duty = tgt_q;
        end else if (duty < tgt_q) begin
            step_duty = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[W-1:0];
        end else if (duty > tgt_q) begin
            // dn_diff[W] set means the subtraction went below zero
            step_duty = (dn_diff[W] || (dn_diff[W-1:0] < tgt_q)) ? tgt_q : dn_diff[W-1:0];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        step_d     = step_q;
        hold_d     = hold_q;
        cfg_clk_d  = cfg_clk_q;
        cfg_pwm_d  = cfg_pwm_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        duty_d     = duty;
        clk_freq_d = clk_freq;
        pwm_freq_d = pwm_freq;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    tgt_d     = target_duty;
                    step_d    = step;
                    hold_d    = hold_cycles;
                    cfg_clk_d = cfg_clk_freq;
                    cfg_pwm_d = cfg_pwm_freq;
                    first_d   = 1'b1;
                    state_d   = STEP;
                end
            end
            STEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if ((duty == tgt_q) && !first_q) begin
                    state_d = DONE;
                end else begin
                    // The first update always commits, carrying the new frequencies.
                    duty_d = step_duty;
                    if (first_q) begin
                        clk_freq_d = cfg_clk_q;
                        pwm_freq_d = cfg_pwm_q;
                    end
                    first_d = 1'b0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hold_q == '0) begin
                    state_d = STEP;
                end else begin
                    cnt_d   = hold_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - W'(1);
                    if (cnt_q == W'(1)) begin
                        state_d = STEP;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flags are registered from the state being entered.
        sync_d = (state_d == SYNC);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            step_q    <= '0;
            hold_q    <= '0;
            cfg_clk_q <= '0;
            cfg_pwm_q <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            duty      <= INIT_DUTY;
            clk_freq  <= DEF_CLK_FREQ;
            pwm_freq  <= DEF_PWM_FREQ;
            sync      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            step_q    <= step_d;
            hold_q    <= hold_d;
            cfg_clk_q <= cfg_clk_d;
            cfg_pwm_q <= cfg_pwm_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            duty      <= duty_d;
            clk_freq  <= clk_freq_d;
            pwm_freq  <= pwm_freq_d;
            sync      <= sync_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl: directed scenarios plus randomized ramps checked
// against a ramp model that predicts sync values and timing arithmetically.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] target_duty;
    logic [31:0] step;
    logic [31:0] hold_cycles;
    logic [31:0] cfg_clk_freq;
    logic [31:0] cfg_pwm_freq;
    logic [31:0] clk_freq;
    logic [31:0] pwm_freq;
    logic [31:0] duty;
    logic        sync;
    logic        busy;
    logic        done;

    pwm_ramp_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .target_duty  (target_duty),
        .step         (step),
        .hold_cycles  (hold_cycles),
        .cfg_clk_freq (cfg_clk_freq),
        .cfg_pwm_freq (cfg_pwm_freq),
        .clk_freq     (clk_freq),
        .pwm_freq     (pwm_freq),
        .duty         (duty),
        .sync         (sync),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] md;
    logic [31:0] mclk;
    logic [31:0] mpwm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One update of the ramp, with plain wide arithmetic to saturate at the target.
    function automatic logic [31:0] model_next(input logic [31:0] d, input logic [31:0] t,
                                               input logic [31:0] s);
        longint ld, lt, ls;
        ld = longint'(d);
        lt = longint'(t);
        ls = longint'(s);
        if (s == 32'd0) return t;
        if (ld < lt) return (ld + ls > lt) ? t : 32'(ld + ls);
        if (ld > lt) return (ld - ls < lt) ? t : 32'(ld - ls);
        return d;
    endfunction

    // Runs one ramp and checks every sync, the done pulse and busy against the model.
    // abort_at > 0 aborts in the cycle following that sync (expects hold > 0).
    task automatic run_ramp(input logic [31:0] t, input logic [31:0] s, input int h,
                            input logic [31:0] cc, input logic [31:0] cp,
                            input int abort_at, input bit keep_start);
        logic [31:0] exp_d[$];
        logic [31:0] nd;
        int          n, nsync, cyc, limit, bad;
        bit          got_done;
        nd = model_next(md, t, s);
        exp_d.push_back(nd);
        while (nd != t) begin
            nd = model_next(nd, t, s);
            exp_d.push_back(nd);
        end
        n = exp_d.size();

        target_duty  = t;
        step         = s;
        hold_cycles  = 32'(h);
        cfg_clk_freq = cc;
        cfg_pwm_freq = cp;
        start        = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        chk("step_nosync", 32'(sync), 32'd0);

        cyc      = 1;
        nsync    = 0;
        bad      = 0;
        got_done = 1'b0;
        limit    = 2 + n * (h + 2) + 8;
        while (!got_done && cyc < limit) begin
            tick();
            cyc++;
            if (sync && done) bad++;
            if (sync) begin
                if (nsync < n) chk($sformatf("sync%0d_duty", nsync), duty, exp_d[nsync]);
                else bad++;
                chk("sync_time", 32'(cyc), 32'(2 + nsync * (h + 2)));
                chk("sync_clk_freq", clk_freq, cc);
                chk("sync_pwm_freq", pwm_freq, cp);
                nsync++;
                if (abort_at == nsync) begin
                    tick();
                    if (sync || done) bad++;
                    abort = 1'b1;
                    start = 1'b0;
                    tick();
                    abort = 1'b0;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_duty", duty, exp_d[nsync-1]);
                    for (int i = 0; i < h + 6; i++) begin
                        tick();
                        if (sync || done || busy) bad++;
                    end
                    chk("abort_quiet", 32'(bad), 32'd0);
                    chk("abort_hold_duty", duty, exp_d[nsync-1]);
                    md   = exp_d[nsync-1];
                    mclk = cc;
                    mpwm = cp;
                    return;
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_time", 32'(cyc), 32'(2 + (n - 1) * (h + 2) + h + 2));
                chk("busy_at_done", 32'(busy), 32'd1);
            end
        end
        chk("done_seen", 32'(got_done), 32'd1);
        chk("sync_count", 32'(nsync), 32'(n));
        start = 1'b0;
        tick();
        chk("busy_fall", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("sync_done_overlap", 32'(bad), 32'd0);
        chk("final_duty", duty, t);
        md   = t;
        mclk = cc;
        mpwm = cp;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        target_duty  = '0;
        step         = '0;
        hold_cycles  = '0;
        cfg_clk_freq = '0;
        cfg_pwm_freq = '0;
        md           = 32'h0;
        mclk         = 32'd1000000;
        mpwm         = 32'd10000;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_duty", duty, 32'h0);
        chk("rst_clk_freq", clk_freq, 32'd1000000);
        chk("rst_pwm_freq", pwm_freq, 32'd10000);
        chk("rst_sync", 32'(sync), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Basic 4-step up-ramp
        run_ramp(32'h7FFF_FFFF, 32'h2000_0000, 3, 32'd50000, 32'd500, 0, 1'b0);

        // Saturation at the top and at the bottom
        run_ramp(32'hF000_0000, 32'h0, 0, 32'd50000, 32'd500, 0, 1'b0);
        run_ramp(32'hFFFF_FFFF, 32'h2000_0000, 2, 32'd50000, 32'd500, 0, 1'b0);
        run_ramp(32'h7FFF_FFFF, 32'h0, 0, 32'd50000, 32'd500, 0, 1'b0);
        run_ramp(32'h0000_0010, 32'h8000_0000, 1, 32'd50000, 32'd500, 0, 1'b0);

        // Jump with step 0, no dwell
        run_ramp(32'h1234_5678, 32'h0, 0, 32'd60000, 32'd600, 0, 1'b0);

        // Target equals current duty: one sync carrying the new pwm_freq
        run_ramp(32'h1234_5678, 32'h0100_0000, 2, 32'd60000, 32'd20000, 0, 1'b0);

        // Abort in WAIT after the 2nd sync, start held high throughout
        run_ramp(32'h0, 32'h0, 0, 32'd1000000, 32'd10000, 0, 1'b0);
        run_ramp(32'h7FFF_FFFF, 32'h2000_0000, 3, 32'd70000, 32'd700, 2, 1'b1);

        // Reset in the middle of a dwell
        target_duty  = 32'hFFFF_0000;
        step         = 32'h1000_0000;
        hold_cycles  = 32'd4;
        cfg_clk_freq = 32'd123;
        cfg_pwm_freq = 32'd45;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_sync", 32'(sync), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_duty", duty, 32'h0);
        chk("mid_rst_clk_freq", clk_freq, 32'd1000000);
        chk("mid_rst_pwm_freq", pwm_freq, 32'd10000);
        chk("mid_rst_sync", 32'(sync), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        md = 32'h0;
        tick();
        run_ramp(32'h3000_0000, 32'h1000_0000, 1, 32'd80000, 32'd800, 0, 1'b0);

        // Randomized ramps
        for (int k = 0; k < 20; k++) begin
            logic [31:0] rt, rs;
            rt = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h0400_0000);
            run_ramp(rt, rs, int'($urandom_range(0, 4)), $urandom, $urandom, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
